// File: rtl/fpu_rsp_buffer.sv
// fpu_rsp_buffer
// Absorbs the never-stalling result pulses of the 3-stage FPU into a small
// circular FIFO and offers them to the FP register-file writeback port with
// valid/ready. It also tracks ops in flight inside the FPU, so the dispatcher
// only fires when a buffer slot is guaranteed for the eventual result.
module fpu_rsp_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // dispatcher side
  input  logic              issue_fire_i,
  output logic              issue_allow_o,
  output logic [CNT_W-1:0]  credit_o,
  // FPU result side
  input  logic              rsp_valid_i,
  input  logic [ADDR_W-1:0] rsp_rd_addr_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  input  logic              rsp_error_i,
  // writeback side
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_rd_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_error_o,
  input  logic              wb_ready_i,
  // control and status
  input  logic              flush_i,
  output logic              overflow_o,
  output logic              protocol_err_o
);

  // Pointer width; DEPTH >= 2 keeps this at least one bit wide.
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ADDR_W + DATA_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  // Storage: each entry is {rd_addr, data, error}; deliberately not reset.
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             overflow_q, overflow_d;
  logic             protocol_err_q, protocol_err_d;

  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             rsp_unexpected;
  logic             issue_illegal;
  logic [CNT_W:0]   reserved;
  logic [CNT_W:0]   credit_ext;
  logic [ENTRY_W-1:0] head_entry;

  // Advance a pointer, wrapping at DEPTH so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode: a push is accepted when there is room or the head
  // leaves in the same cycle; a flush discards any same-cycle push.
  always_comb begin
    full           = (occupancy_q == DEPTH_CNT);
    pop            = wb_valid_o && wb_ready_i;
    push           = rsp_valid_i && !flush_i && (!full || pop);
    drop           = rsp_valid_i && !flush_i && full && !pop;
    rsp_unexpected = rsp_valid_i && (inflight_q == '0) && !issue_fire_i;
    issue_illegal  = issue_fire_i && !issue_allow_o;
  end

  // Credit view: slots neither occupied nor promised to an op in flight.
  // After a protocol violation the sum can exceed DEPTH; credit then
  // reads as zero rather than wrapping to a large value.
  always_comb begin
    reserved      = {1'b0, occupancy_q} + {1'b0, inflight_q};
    issue_allow_o = (reserved < DEPTH_EXT);
    credit_ext    = issue_allow_o ? (DEPTH_EXT - reserved) : '0;
    credit_o      = credit_ext[CNT_W-1:0];
  end

  // FIFO pointer and occupancy next-state; flush snaps the read pointer
  // onto the write pointer so the buffer looks empty next cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occupancy_d = occupancy_q;
    if (flush_i) begin
      rd_ptr_d    = wr_ptr_q;
      occupancy_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        occupancy_d = occupancy_q + CNT_W'(1);
      end else if (pop && !push) begin
        occupancy_d = occupancy_q - CNT_W'(1);
      end
    end
  end

  // In-flight tracking: issue adds one, a response removes one, both
  // together cancel. Flush leaves it alone because those results will
  // still come out of the FPU. Saturates at 0 and DEPTH.
  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire_i && !rsp_valid_i) begin
      if (inflight_q != DEPTH_CNT) begin
        inflight_d = inflight_q + CNT_W'(1);
      end
    end else if (rsp_valid_i && !issue_fire_i) begin
      if (inflight_q != '0) begin
        inflight_d = inflight_q - CNT_W'(1);
      end
    end
  end

  // Sticky error flags accumulate until reset.
  always_comb begin
    overflow_d     = overflow_q || drop;
    protocol_err_d = protocol_err_q || rsp_unexpected || issue_illegal;
  end

  // Control state register with synchronous reset; pulses during reset
  // are ignored because the reset branch wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occupancy_q    <= '0;
      inflight_q     <= '0;
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occupancy_q    <= occupancy_d;
      inflight_q     <= inflight_d;
      overflow_q     <= overflow_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Entry write; on a full push+pop the slot written is the one leaving.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem[wr_ptr_q] <= {rsp_rd_addr_i, rsp_data_i, rsp_error_i};
    end
  end

  // First-word fall-through head; it only changes on pop or flush, so it
  // stays stable while the writeback port holds off.
  always_comb begin
    head_entry     = mem[rd_ptr_q];
    wb_valid_o     = (occupancy_q != '0);
    wb_rd_addr_o   = head_entry[ENTRY_W-1 -: ADDR_W];
    wb_data_o      = head_entry[DATA_W:1];
    wb_error_o     = head_entry[0];
    overflow_o     = overflow_q;
    protocol_err_o = protocol_err_q;
  end

endmodule

// File: tb/tb_fpu_rsp_buffer.sv
// tb_fpu_rsp_buffer
// Directed bench for fpu_rsp_buffer (DEPTH=4): reset, single op, fill and
// drain, full push+pop, overflow drop and flush with a late response.
module tb_fpu_rsp_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_fire_i;
  logic        issue_allow_o;
  logic [2:0]  credit_o;
  logic        rsp_valid_i;
  logic [4:0]  rsp_rd_addr_i;
  logic [31:0] rsp_data_i;
  logic        rsp_error_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_error_o;
  logic        wb_ready_i;
  logic        flush_i;
  logic        overflow_o;
  logic        protocol_err_o;

  int checks = 0;
  int errors = 0;

  fpu_rsp_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_fire_i   (issue_fire_i),
    .issue_allow_o  (issue_allow_o),
    .credit_o       (credit_o),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_rd_addr_i  (rsp_rd_addr_i),
    .rsp_data_i     (rsp_data_i),
    .rsp_error_i    (rsp_error_i),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_addr_o   (wb_rd_addr_o),
    .wb_data_o      (wb_data_o),
    .wb_error_o     (wb_error_o),
    .wb_ready_i     (wb_ready_i),
    .flush_i        (flush_i),
    .overflow_o     (overflow_o),
    .protocol_err_o (protocol_err_o)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, then settle #1 past the rising edge.
  task automatic applyStimulus(input logic issue, input logic rspv,
                               input logic [4:0] rd, input logic [31:0] data,
                               input logic err, input logic ready,
                               input logic flush);
    issue_fire_i  = issue;
    rsp_valid_i   = rspv;
    rsp_rd_addr_i = rd;
    rsp_data_i    = data;
    rsp_error_i   = err;
    wb_ready_i    = ready;
    flush_i       = flush;
    @(posedge clk_i);
    #1;
  endtask

  // Idle cycle with only the writeback ready level chosen.
  task automatic idle(input logic ready);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, ready, 1'b0);
  endtask

  // Two reset cycles with noise on the inputs, then release.
  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd30, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
  endtask

  // One comparison, counted, with a FAIL report when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence; every expected value is worked out by hand.
  initial begin
    rst_i = 1'b1;
    issue_fire_i = 1'b0; rsp_valid_i = 1'b0; rsp_rd_addr_i = '0;
    rsp_data_i = '0; rsp_error_i = 1'b0; wb_ready_i = 1'b0; flush_i = 1'b0;

    // Reset then idle
    doReset();
    idle(1'b0);
    checkOutput("rst_credit", 32'(credit_o), 32'd4);
    checkOutput("rst_allow", 32'(issue_allow_o), 32'd1);
    checkOutput("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_o), 32'd0);
    checkOutput("rst_protocol_err", 32'(protocol_err_o), 32'd0);

    // Single op: issue, two idle cycles, response, popped next edge
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("single_credit_issued", 32'(credit_o), 32'd3);
    idle(1'b1);
    idle(1'b1);
    checkOutput("single_wb_valid_wait", 32'(wb_valid_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h4040_0000, 1'b0, 1'b1, 1'b0);
    checkOutput("single_wb_valid", 32'(wb_valid_o), 32'd1);
    checkOutput("single_rd", 32'(wb_rd_addr_o), 32'd5);
    checkOutput("single_data", wb_data_o, 32'h4040_0000);
    checkOutput("single_err", 32'(wb_error_o), 32'd0);
    checkOutput("single_credit_buffered", 32'(credit_o), 32'd3);
    idle(1'b1);
    checkOutput("single_wb_valid_gone", 32'(wb_valid_o), 32'd0);
    checkOutput("single_credit_back", 32'(credit_o), 32'd4);

    // Fill with writeback stalled: 4 issues then 4 responses rd 1..4
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_allow_3", 32'(issue_allow_o), 32'd1);
    checkOutput("fill_credit_3", 32'(credit_o), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_allow_4", 32'(issue_allow_o), 32'd0);
    checkOutput("fill_credit_4", 32'(credit_o), 32'd0);
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("fill_full_credit", 32'(credit_o), 32'd0);
    checkOutput("fill_full_valid", 32'(wb_valid_o), 32'd1);
    idle(1'b0);
    checkOutput("fill_hold_rd", 32'(wb_rd_addr_o), 32'd1);
    checkOutput("fill_hold_data", wb_data_o, 32'h101);
    for (int i = 2; i <= 4; i++) begin
      idle(1'b1);
      checkOutput($sformatf("drain_rd_%0d", i), 32'(wb_rd_addr_o), 32'(i));
      checkOutput($sformatf("drain_data_%0d", i), wb_data_o, 32'h100 + 32'(i));
    end
    idle(1'b1);
    checkOutput("drain_empty", 32'(wb_valid_o), 32'd0);
    checkOutput("drain_credit", 32'(credit_o), 32'd4);
    checkOutput("drain_overflow", 32'(overflow_o), 32'd0);
    checkOutput("drain_protocol_err", 32'(protocol_err_o), 32'd0);

    // Full FIFO with simultaneous pop and push of rd 9
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b0, 1'b1, 5'(i), 32'h10 + 32'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b0);
    checkOutput("pp_rd_2", 32'(wb_rd_addr_o), 32'd2);
    checkOutput("pp_credit", 32'(credit_o), 32'd0);
    checkOutput("pp_overflow", 32'(overflow_o), 32'd0);
    checkOutput("pp_protocol_err", 32'(protocol_err_o), 32'd1);
    idle(1'b1);
    checkOutput("pp_rd_3", 32'(wb_rd_addr_o), 32'd3);
    idle(1'b1);
    checkOutput("pp_rd_4", 32'(wb_rd_addr_o), 32'd4);
    idle(1'b1);
    checkOutput("pp_rd_9", 32'(wb_rd_addr_o), 32'd9);
    checkOutput("pp_data_9", wb_data_o, 32'h99);
    idle(1'b1);
    checkOutput("pp_empty", 32'(wb_valid_o), 32'd0);

    // Overflow: full, stalled, illegal issue then an extra response
    doReset();
    checkOutput("rst2_protocol_err", 32'(protocol_err_o), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b0, 1'b1, 5'(i), 32'h20 + 32'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_pre_protocol_err", 32'(protocol_err_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_issue_protocol_err", 32'(protocol_err_o), 32'd1);
    checkOutput("ovf_issue_overflow", 32'(overflow_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_overflow", 32'(overflow_o), 32'd1);
    checkOutput("ovf_head_rd", 32'(wb_rd_addr_o), 32'd1);
    checkOutput("ovf_head_data", wb_data_o, 32'h21);
    for (int i = 2; i <= 4; i++) begin
      idle(1'b1);
      checkOutput($sformatf("ovf_drain_rd_%0d", i), 32'(wb_rd_addr_o), 32'(i));
    end
    idle(1'b1);
    checkOutput("ovf_drain_empty", 32'(wb_valid_o), 32'd0);
    checkOutput("ovf_drain_credit", 32'(credit_o), 32'd4);
    checkOutput("ovf_sticky", 32'(overflow_o), 32'd1);

    // Flush: 2 buffered + 1 in flight, late response with error lands
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd2, 32'h32, 1'b0, 1'b0, 1'b0);
    checkOutput("fl_pre_credit", 32'(credit_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("fl_credit", 32'(credit_o), 32'd3);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    checkOutput("fl_late_valid", 32'(wb_valid_o), 32'd1);
    checkOutput("fl_late_rd", 32'(wb_rd_addr_o), 32'd6);
    checkOutput("fl_late_err", 32'(wb_error_o), 32'd1);
    checkOutput("fl_late_credit", 32'(credit_o), 32'd3);
    idle(1'b1);
    checkOutput("fl_final_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("fl_final_credit", 32'(credit_o), 32'd4);
    checkOutput("fl_protocol_err", 32'(protocol_err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
